// File: rtl/inst_fetch_ctrl.sv
// Instruction-SRAM fetch controller between pre-IF and IF: request FSM, outstanding/cancel
// tracking and a one-entry return buffer. Optional perf counters under INST_FETCH_PERF_CNT_EN.
module inst_fetch_ctrl #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        excep_flush_i,
   input  logic        pi_valid_i,
   input  logic [31:0] pi_pc_i,
   input  logic        if_allowin_i,
   input  logic        if_valid_i,
   input  logic        id_allowin_i,
   output logic        pi_ready_go_o,
   output logic        inst_sram_req_o,
   output logic [31:0] inst_sram_addr_o,
   input  logic        inst_sram_addr_ok_i,
   input  logic        inst_sram_data_ok_i,
   input  logic [31:0] inst_sram_rdata_i,
   output logic        if_data_ok_o,
   output logic [31:0] if_rdata_o,
   output logic        inst_rdata_buffer_ok_o,
   output logic [31:0] inst_rdata_buffer_rdata_o,
   output logic [31:0] perf_cancel_cnt_o,
   output logic [31:0] perf_stall_cnt_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0] cancel_q, cancel_d;
   logic             drop_q, drop_d;
   logic             buf_valid_q, buf_valid_d;
   logic [31:0]      buf_data_q, buf_data_d;

   logic             in_req;
   logic             accept;
   logic             issue;
   logic             data_ok;
   logic             fwd_ok;
   logic [CNT_W:0]   owed;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      in_req  = (state_q == S_REQ);
      accept  = in_req && inst_sram_addr_ok_i;
      data_ok = inst_sram_data_ok_i;
      fwd_ok  = data_ok && (cancel_q == '0) && !excep_flush_i;
      issue   = (state_q == S_IDLE) && pi_valid_i && if_allowin_i && !excep_flush_i
                && !buf_valid_q && (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

      state_d = state_q;
      addr_d  = addr_q;
      if (issue) begin
         state_d = S_REQ;
         addr_d  = pi_pc_i;
      end else if (accept) begin
         state_d = S_IDLE;
      end

      out_cnt_d = out_cnt_q;
      case ({accept, data_ok})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: out_cnt_d = out_cnt_q;
      endcase

      // Responses still owed after this cycle; a pending REQ will be answered once accepted.
      owed = {1'b0, out_cnt_q} + {{CNT_W{1'b0}}, in_req} - {{CNT_W{1'b0}}, data_ok};

      cancel_d = cancel_q;
      if (excep_flush_i) begin
         cancel_d = owed[CNT_W-1:0];
      end else if (data_ok && (cancel_q != '0)) begin
         cancel_d = cancel_q - 1'b1;
      end

      drop_d = drop_q;
      if (accept) begin
         drop_d = 1'b0;
      end else if (in_req && excep_flush_i) begin
         drop_d = 1'b1;
      end

      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      if (excep_flush_i) begin
         buf_valid_d = 1'b0;
      end else if (fwd_ok && if_valid_i && !id_allowin_i) begin
         buf_valid_d = 1'b1;
         buf_data_d  = inst_sram_rdata_i;
      end else if (buf_valid_q && id_allowin_i) begin
         buf_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         out_cnt_q   <= '0;
         cancel_q    <= '0;
         drop_q      <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_cnt_q   <= out_cnt_d;
         cancel_q    <= cancel_d;
         drop_q      <= drop_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign inst_sram_req_o           = in_req;
   assign inst_sram_addr_o          = addr_q;
   assign pi_ready_go_o             = accept && !excep_flush_i && !drop_q;
   assign if_data_ok_o              = fwd_ok;
   assign if_rdata_o                = inst_sram_rdata_i;
   assign inst_rdata_buffer_ok_o    = buf_valid_q;
   assign inst_rdata_buffer_rdata_o = buf_data_q;

`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] perf_cancel_q, perf_cancel_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_cancel_d = perf_cancel_q;
      perf_stall_d  = perf_stall_q;
      if (data_ok && (cancel_q != '0)) perf_cancel_d = perf_cancel_q + 32'd1;
      if (in_req && !inst_sram_addr_ok_i) perf_stall_d = perf_stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cancel_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_cancel_q <= perf_cancel_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_cancel_cnt_o = perf_cancel_q;
   assign perf_stall_cnt_o  = perf_stall_q;
`else
   assign perf_cancel_cnt_o = 32'd0;
   assign perf_stall_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: fetch, back-pressure, outstanding limit, flush cases, reset.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        excep_flush;
   logic        pi_valid;
   logic [31:0] pi_pc;
   logic        if_allowin;
   logic        if_valid;
   logic        id_allowin;
   logic        pi_ready_go;
   logic        sram_req;
   logic [31:0] sram_addr;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        if_data_ok;
   logic [31:0] if_rdata;
   logic        buf_ok;
   logic [31:0] buf_rdata;
   logic [31:0] perf_cancel;
   logic [31:0] perf_stall;

   int checks = 0;
   int errors = 0;

   inst_fetch_ctrl dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .excep_flush_i             (excep_flush),
      .pi_valid_i                (pi_valid),
      .pi_pc_i                   (pi_pc),
      .if_allowin_i              (if_allowin),
      .if_valid_i                (if_valid),
      .id_allowin_i              (id_allowin),
      .pi_ready_go_o             (pi_ready_go),
      .inst_sram_req_o           (sram_req),
      .inst_sram_addr_o          (sram_addr),
      .inst_sram_addr_ok_i       (addr_ok),
      .inst_sram_data_ok_i       (data_ok),
      .inst_sram_rdata_i         (rdata),
      .if_data_ok_o              (if_data_ok),
      .if_rdata_o                (if_rdata),
      .inst_rdata_buffer_ok_o    (buf_ok),
      .inst_rdata_buffer_rdata_o (buf_rdata),
      .perf_cancel_cnt_o         (perf_cancel),
      .perf_stall_cnt_o          (perf_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Issue one fetch with addr_ok in the first REQ cycle; returns in IDLE with addr_ok low.
   task automatic do_fetch(input logic [31:0] pc);
      pi_valid   = 1'b1;
      pi_pc      = pc;
      if_allowin = 1'b1;
      tick();
      pi_valid = 1'b0;
      addr_ok  = 1'b1;
      tick();
      addr_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; excep_flush = 1'b0; pi_valid = 1'b0; pi_pc = 32'h0;
      if_allowin = 1'b0; if_valid = 1'b0; id_allowin = 1'b0;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
      tick(); tick();
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", sram_req); end
      checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %08h want 00000000", sram_addr); end
      checks++; if (pi_ready_go !== 1'b0) begin errors++; $display("FAIL rst_ready_go got %0h want 0", pi_ready_go); end
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok got %0h want 0", if_data_ok); end
      checks++; if (buf_ok !== 1'b0) begin errors++; $display("FAIL rst_buf_ok got %0h want 0", buf_ok); end
      checks++; if (buf_rdata !== 32'h0) begin errors++; $display("FAIL rst_buf_rdata got %08h want 00000000", buf_rdata); end
      checks++; if (dut.out_cnt_q !== 2'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", dut.out_cnt_q); end
      rst_n = 1'b1;
      if_valid = 1'b1; id_allowin = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      pi_valid = 1'b1; pi_pc = 32'h1c000000; if_allowin = 1'b1;
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL sf_req_latency got %0h want 0", sram_req); end
      tick();
      pi_valid = 1'b0;
      settle();
      checks++; if (sram_req !== 1'b1) begin errors++; $display("FAIL sf_req got %0h want 1", sram_req); end
      checks++; if (sram_addr !== 32'h1c000000) begin errors++; $display("FAIL sf_addr got %08h want 1c000000", sram_addr); end
      checks++; if (pi_ready_go !== 1'b0) begin errors++; $display("FAIL sf_ready_go_early got %0h want 0", pi_ready_go); end
      tick();
      addr_ok = 1'b1;
      settle();
      checks++; if (pi_ready_go !== 1'b1) begin errors++; $display("FAIL sf_ready_go got %0h want 1", pi_ready_go); end
      tick();
      addr_ok = 1'b0;
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL sf_req_drop got %0h want 0", sram_req); end
      checks++; if (pi_ready_go !== 1'b0) begin errors++; $display("FAIL sf_ready_go_once got %0h want 0", pi_ready_go); end
      tick();
      data_ok = 1'b1; rdata = 32'h02c00413;
      settle();
      checks++; if (if_data_ok !== 1'b1) begin errors++; $display("FAIL sf_data_ok got %0h want 1", if_data_ok); end
      checks++; if (if_rdata !== 32'h02c00413) begin errors++; $display("FAIL sf_rdata got %08h want 02c00413", if_rdata); end
      tick();
      data_ok = 1'b0;
      settle();
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL sf_data_ok_once got %0h want 0", if_data_ok); end
      checks++; if (dut.out_cnt_q !== 2'd0) begin errors++; $display("FAIL sf_outstanding got %0d want 0", dut.out_cnt_q); end
   endtask

   task automatic test_back_pressure();
      do_fetch(32'h1c000004);
      data_ok = 1'b1; rdata = 32'h02800c0c; if_valid = 1'b1; id_allowin = 1'b0;
      settle();
      checks++; if (if_data_ok !== 1'b1) begin errors++; $display("FAIL bp_data_ok got %0h want 1", if_data_ok); end
      checks++; if (buf_ok !== 1'b0) begin errors++; $display("FAIL bp_buf_early got %0h want 0", buf_ok); end
      tick();
      data_ok = 1'b0; pi_valid = 1'b1; pi_pc = 32'h1c000008;
      settle();
      checks++; if (buf_ok !== 1'b1) begin errors++; $display("FAIL bp_buf_ok got %0h want 1", buf_ok); end
      checks++; if (buf_rdata !== 32'h02800c0c) begin errors++; $display("FAIL bp_buf_rdata got %08h want 02800c0c", buf_rdata); end
      tick();
      pi_valid = 1'b0; id_allowin = 1'b1;
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL bp_issue_blocked got %0h want 0", sram_req); end
      checks++; if (buf_ok !== 1'b1) begin errors++; $display("FAIL bp_buf_hold got %0h want 1", buf_ok); end
      tick();
      settle();
      checks++; if (buf_ok !== 1'b0) begin errors++; $display("FAIL bp_buf_clear got %0h want 0", buf_ok); end
   endtask

   task automatic test_max_outstanding();
      do_fetch(32'h1c000020);
      do_fetch(32'h1c000024);
      pi_valid = 1'b1; pi_pc = 32'h1c000028;
      tick();
      pi_valid = 1'b0;
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL mo_gate got %0h want 0", sram_req); end
      checks++; if (dut.out_cnt_q !== 2'd2) begin errors++; $display("FAIL mo_outstanding got %0d want 2", dut.out_cnt_q); end
      data_ok = 1'b1; rdata = 32'h0000aaaa;
      settle();
      checks++; if (if_data_ok !== 1'b1) begin errors++; $display("FAIL mo_data_ok0 got %0h want 1", if_data_ok); end
      tick();
      rdata = 32'h0000bbbb;
      settle();
      checks++; if (if_data_ok !== 1'b1) begin errors++; $display("FAIL mo_data_ok1 got %0h want 1", if_data_ok); end
      tick();
      data_ok = 1'b0;
      settle();
      checks++; if (dut.out_cnt_q !== 2'd0) begin errors++; $display("FAIL mo_drain got %0d want 0", dut.out_cnt_q); end
   endtask

   task automatic test_flush_outstanding();
      do_fetch(32'h1c000040);
      do_fetch(32'h1c000044);
      excep_flush = 1'b1;
      settle();
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL fo_flush_data_ok got %0h want 0", if_data_ok); end
      tick();
      excep_flush = 1'b0; data_ok = 1'b1; rdata = 32'h11110000;
      settle();
      checks++; if (dut.cancel_q !== 2'd2) begin errors++; $display("FAIL fo_cancel got %0d want 2", dut.cancel_q); end
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL fo_discard0 got %0h want 0", if_data_ok); end
      tick();
      rdata = 32'h11110001;
      settle();
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL fo_discard1 got %0h want 0", if_data_ok); end
      tick();
      data_ok = 1'b0;
      settle();
      checks++; if (dut.cancel_q !== 2'd0) begin errors++; $display("FAIL fo_cancel_done got %0d want 0", dut.cancel_q); end
      do_fetch(32'h1c000100);
      data_ok = 1'b1; rdata = 32'h22220000;
      settle();
      checks++; if (if_data_ok !== 1'b1) begin errors++; $display("FAIL fo_forward got %0h want 1", if_data_ok); end
      tick();
      data_ok = 1'b0;
   endtask

   task automatic test_flush_in_req();
      pi_valid = 1'b1; pi_pc = 32'h1c000200;
      tick();
      pi_valid = 1'b0; excep_flush = 1'b1;
      settle();
      checks++; if (sram_req !== 1'b1) begin errors++; $display("FAIL fr_req_on_flush got %0h want 1", sram_req); end
      tick();
      excep_flush = 1'b0;
      settle();
      checks++; if (dut.cancel_q !== 2'd1) begin errors++; $display("FAIL fr_cancel got %0d want 1", dut.cancel_q); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (sram_req !== 1'b1) begin errors++; $display("FAIL fr_req_hold%0d got %0h want 1", i, sram_req); end
         checks++; if (sram_addr !== 32'h1c000200) begin errors++; $display("FAIL fr_addr_hold%0d got %08h want 1c000200", i, sram_addr); end
         tick();
      end
      addr_ok = 1'b1;
      settle();
      checks++; if (pi_ready_go !== 1'b0) begin errors++; $display("FAIL fr_ready_go got %0h want 0", pi_ready_go); end
      tick();
      addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h33330000;
      settle();
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL fr_discard got %0h want 0", if_data_ok); end
      tick();
      data_ok = 1'b0;
      settle();
      checks++; if (dut.cancel_q !== 2'd0) begin errors++; $display("FAIL fr_cancel_done got %0d want 0", dut.cancel_q); end
      checks++; if (dut.out_cnt_q !== 2'd0) begin errors++; $display("FAIL fr_outstanding got %0d want 0", dut.out_cnt_q); end
   endtask

   task automatic test_flush_with_data();
      do_fetch(32'h1c000300);
      do_fetch(32'h1c000304);
      data_ok = 1'b1; rdata = 32'h44440000; if_valid = 1'b1; id_allowin = 1'b0;
      tick();
      excep_flush = 1'b1; rdata = 32'h44440001;
      settle();
      checks++; if (if_data_ok !== 1'b0) begin errors++; $display("FAIL fd_data_ok got %0h want 0", if_data_ok); end
      checks++; if (buf_ok !== 1'b1) begin errors++; $display("FAIL fd_buf_before got %0h want 1", buf_ok); end
      tick();
      excep_flush = 1'b0; data_ok = 1'b0; id_allowin = 1'b1;
      settle();
      checks++; if (dut.cancel_q !== 2'd0) begin errors++; $display("FAIL fd_cancel got %0d want 0", dut.cancel_q); end
      checks++; if (buf_ok !== 1'b0) begin errors++; $display("FAIL fd_buf_cleared got %0h want 0", buf_ok); end
      checks++; if (dut.out_cnt_q !== 2'd0) begin errors++; $display("FAIL fd_outstanding got %0d want 0", dut.out_cnt_q); end
   endtask

   task automatic test_reset_mid();
      pi_valid = 1'b1; pi_pc = 32'h1c000400;
      tick();
      pi_valid = 1'b0;
      settle();
      checks++; if (sram_req !== 1'b1) begin errors++; $display("FAIL rm_req got %0h want 1", sram_req); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rm_req_cleared got %0h want 0", sram_req); end
      checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got %08h want 00000000", sram_addr); end
   endtask

   task automatic test_perf();
`ifndef INST_FETCH_PERF_CNT_EN
      checks++; if (perf_cancel !== 32'd0) begin errors++; $display("FAIL perf_cancel got %0d want 0", perf_cancel); end
      checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL perf_stall got %0d want 0", perf_stall); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_pressure();
      test_max_outstanding();
      test_flush_outstanding();
      test_flush_in_req();
      test_flush_with_data();
      test_perf();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
